// File: rtl/product_accumulator_if.sv
// Handshake bundle between a product source, the accumulator and the result consumer.
interface product_accumulator_if #(
  parameter int unsigned PW = 16,
  parameter int unsigned AW = 24
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] product;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic          overflow;

  // Source/consumer side
  modport master (
    output in_valid, product, out_ready,
    input  in_ready, out_valid, sum, overflow
  );

  // Accumulator side
  modport slave (
    input  in_valid, product, out_ready,
    output in_ready, out_valid, sum, overflow
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums each group of CNT accepted unsigned products and holds the result until consumed.
module product_accumulator #(
  parameter int unsigned PW  = 16,
  parameter int unsigned CNT = 4,
  parameter int unsigned AW  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  product_accumulator_if.slave   bus
);

  localparam int unsigned CW = (CNT > 1) ? $clog2(CNT) : 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_int_q, ovf_int_d;
  logic [AW-1:0] sum_q, sum_d;
  logic          ovf_q, ovf_d;

  logic [PW-1:0] product_c;
  logic [AW:0]   add_c;
  logic          in_ready_c;
  logic          accept_c;

  // One extra bit on the adder exposes the carry out of the accumulator
  always_comb begin
    product_c  = bus.product;
    add_c      = {1'b0, acc_q} + (AW+1)'(product_c);
    in_ready_c = (state_q == ACC) && !clear;
    accept_c   = bus.in_valid && in_ready_c;
  end

  // Next-state and datapath update; clear aborts the group in either state
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    count_d   = count_q;
    ovf_int_d = ovf_int_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    if (clear) begin
      state_d   = ACC;
      acc_d     = '0;
      count_d   = '0;
      ovf_int_d = 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept_c) begin
            acc_d     = add_c[AW-1:0];
            ovf_int_d = ovf_int_q | add_c[AW];
            if (count_q == CW'(CNT - 1)) begin
              sum_d   = add_c[AW-1:0];
              ovf_d   = ovf_int_q | add_c[AW];
              state_d = HOLD;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_d     = '0;
            count_d   = '0;
            ovf_int_d = 1'b0;
            state_d   = ACC;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACC;
      acc_q     <= '0;
      count_q   <= '0;
      ovf_int_q <= 1'b0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      ovf_int_q <= ovf_int_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.sum       = sum_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench: three accumulator configurations driven in lockstep and checked against a group-sum model.
module tb_product_accumulator;

  localparam int NI = 3;
  localparam int unsigned CNT_K [NI] = '{4, 4, 1};
  localparam int unsigned AW_K  [NI] = '{24, 17, 16};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] product = '0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  bit armed    = 1'b0;

  always #5 clk = ~clk;

  product_accumulator_if #(.PW(16), .AW(24)) ifa ();
  product_accumulator_if #(.PW(16), .AW(17)) ifb ();
  product_accumulator_if #(.PW(16), .AW(16)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifa.product = product;  assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.product = product;  assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.product = product;  assign ifc.out_ready = out_ready;

  product_accumulator #(.PW(16), .CNT(4), .AW(24)) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(ifa.slave));
  product_accumulator #(.PW(16), .CNT(4), .AW(17)) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(ifb.slave));
  product_accumulator #(.PW(16), .CNT(1), .AW(16)) dut_c (.clk(clk), .rst(rst), .clear(clear), .bus(ifc.slave));

  // Gather DUT outputs into arrays for the per-cycle compare
  logic                d_ir [NI];
  logic                d_ov [NI];
  longint unsigned     d_sum[NI];
  logic                d_of [NI];
  always_comb begin
    d_ir[0] = ifa.in_ready; d_ov[0] = ifa.out_valid; d_sum[0] = 64'(ifa.sum); d_of[0] = ifa.overflow;
    d_ir[1] = ifb.in_ready; d_ov[1] = ifb.out_valid; d_sum[1] = 64'(ifb.sum); d_of[1] = ifb.overflow;
    d_ir[2] = ifc.in_ready; d_ov[2] = ifc.out_valid; d_sum[2] = 64'(ifc.sum); d_of[2] = ifc.overflow;
  end

  // Group-level model: a running total of accepted products, reduced modulo 2^AW when the group completes
  bit              m_hold[NI];
  int unsigned     m_n   [NI];
  longint unsigned m_tot [NI];
  longint unsigned m_sum [NI];
  bit              m_ovf [NI];

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        m_hold[k] = 1'b0; m_n[k] = 0; m_tot[k] = 0; m_sum[k] = 0; m_ovf[k] = 1'b0;
      end else if (clear) begin
        m_hold[k] = 1'b0; m_n[k] = 0; m_tot[k] = 0;
      end else if (m_hold[k]) begin
        if (out_ready) begin
          m_hold[k] = 1'b0; m_n[k] = 0; m_tot[k] = 0;
        end
      end else if (in_valid) begin
        m_tot[k] = m_tot[k] + 64'(product);
        m_n[k]   = m_n[k] + 1;
        if (m_n[k] == CNT_K[k]) begin
          m_sum[k]  = m_tot[k] % (64'd1 << AW_K[k]);
          m_ovf[k]  = (m_tot[k] >= (64'd1 << AW_K[k]));
          m_hold[k] = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, k, $time, act, exp);
    end
  endtask

  // Per-cycle compare on the falling edge
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < NI; k++) begin
        chk("in_ready",  k, 64'(d_ir[k]), 64'(!m_hold[k] && !clear));
        chk("out_valid", k, 64'(d_ov[k]), 64'(m_hold[k]));
        chk("sum",       k, d_sum[k],     m_sum[k]);
        chk("overflow",  k, 64'(d_of[k]), 64'(m_ovf[k]));
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] p, input logic ordy,
                       input logic clr = 1'b0, input logic r = 1'b0);
    in_valid  = v;
    product   = p;
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    drive(1'b0, 16'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [15:0] stream [4];
    stream[0] = 16'd8; stream[1] = 16'd2916; stream[2] = 16'd0; stream[3] = 16'd65025;

    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0);
    armed = 1'b1;
    chk("reset out_valid", 0, 64'(ifa.out_valid), 64'd0);
    chk("reset in_ready",  0, 64'(ifa.in_ready),  64'd1);
    chk("reset sum",       0, 64'(ifa.sum),       64'd0);

    // Back-to-back stream
    for (int i = 0; i < 4; i++) drive(1'b1, stream[i], 1'b0);
    chk("stream sum",       0, 64'(ifa.sum),       64'd67949);
    chk("stream overflow",  0, 64'(ifa.overflow),  64'd0);
    chk("stream out_valid", 0, 64'(ifa.out_valid), 64'd1);
    chk("stream in_ready",  0, 64'(ifa.in_ready),  64'd0);
    chk("stream sum aw17",  1, 64'(ifb.sum),       64'd67949);
    chk("cnt1 sum",         2, 64'(ifc.sum),       64'd8);

    // Stalled consumer while products keep arriving
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'd7, 1'b0);
      chk("hold sum",      0, 64'(ifa.sum),      64'd67949);
      chk("hold in_ready", 0, 64'(ifa.in_ready), 64'd0);
    end
    drive(1'b1, 16'd7, 1'b1);
    chk("release out_valid", 0, 64'(ifa.out_valid), 64'd0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd7, 1'b0);
    chk("sevens sum", 0, 64'(ifa.sum), 64'd28);

    // Stream with gaps; junk on idle cycles must be ignored
    flush();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, stream[i], 1'b0);
      if (i < 3) drive(1'b0, 16'($urandom), 1'b0);
    end
    chk("gap out_valid", 0, 64'(ifa.out_valid), 64'd1);
    chk("gap sum",       0, 64'(ifa.sum),       64'd67949);

    // Narrow accumulator wraps
    flush();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd65025, 1'b0);
    chk("wrap sum",      1, 64'(ifb.sum),      64'd129028);
    chk("wrap overflow", 1, 64'(ifb.overflow), 64'd1);
    chk("nowrap sum",    0, 64'(ifa.sum),      64'd260100);
    drive(1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd1, 1'b0);
    chk("after wrap sum",      1, 64'(ifb.sum),      64'd4);
    chk("after wrap overflow", 1, 64'(ifb.overflow), 64'd0);

    // Abort mid-group; product in the clear cycle is dropped
    flush();
    drive(1'b1, 16'd100, 1'b0);
    drive(1'b1, 16'd200, 1'b0);
    drive(1'b1, 16'd999, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) drive(1'b1, 16'(i), 1'b0);
    chk("clear sum", 0, 64'(ifa.sum), 64'd10);

    // Single-product groups
    flush();
    drive(1'b1, 16'd12345, 1'b0);
    chk("cnt1 single sum",  2, 64'(ifc.sum),       64'd12345);
    chk("cnt1 out_valid",   2, 64'(ifc.out_valid), 64'd1);

    // Reset while holding a result
    flush();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd50, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("rst out_valid", 0, 64'(ifa.out_valid), 64'd0);
    chk("rst in_ready",  0, 64'(ifa.in_ready),  64'd1);
    chk("rst sum",       0, 64'(ifa.sum),       64'd0);
    chk("rst overflow",  0, 64'(ifa.overflow),  64'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 3) == 0) ? 16'd65025 : 16'($urandom),
            1'($urandom),
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 200) == 0);
    end
    drive(1'b0, 16'd0, 1'b0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
